// File: rtl/axi_img_master.sv
`default_nettype none
// ============================================================================
// Module  : axi_img_master
// Brief   : AXI4-Lite write initiator that streams one image frame into the
//           accelerator image port, one single-beat write per 8-bit pixel,
//           with at most one transaction outstanding.
// Config  : AXI_IMG_MASTER_ABORT_EN - when defined, an error response ends
//           the frame immediately instead of writing the remaining pixels.
// Rev     : 1.0 - initial release
// ============================================================================
module axi_img_master #(
  parameter int unsigned N_PIXELS    = 256,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter logic [31:0] ADDR_STRIDE = 32'd1
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        START,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR,
  input  logic [7:0]  PIX_DATA,
  input  logic        PIX_VALID,
  output logic        PIX_READY,
  output logic [31:0] AWADDR,
  output logic [2:0]  AWPROT,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [31:0] WDATA,
  output logic [3:0]  WSTRB,
  output logic        WVALID,
  input  logic        WREADY,
  input  logic [1:0]  BRESP,
  input  logic        BVALID,
  output logic        BREADY
);

  localparam int unsigned      CNT_W    = $clog2(N_PIXELS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_PIXELS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WRITE = 3'd2,
    S_RESP  = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             aw_done_q, aw_done_d;
  logic             w_done_q, w_done_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             pix_ready_q, pix_ready_d;
  logic             awvalid_q, awvalid_d;
  logic             wvalid_q, wvalid_d;
  logic             bready_q, bready_d;
  logic [31:0]      awaddr_q, awaddr_d;
  logic [31:0]      wdata_q, wdata_d;

  logic             resp_err;
  logic             last_pix;
  logic             frame_end;

  assign resp_err = (BRESP != 2'b00);
  assign last_pix = (idx_q == LAST_IDX);

`ifdef AXI_IMG_MASTER_ABORT_EN
  assign frame_end = last_pix | resp_err;
`else
  assign frame_end = last_pix;
`endif

  // Next-state logic; every output register is derived from the next state
  // so that all AXI and pixel-side outputs come straight from flops.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    error_d   = error_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_FETCH;
          idx_d   = '0;
          error_d = 1'b0;
        end
      end
      S_FETCH: begin
        if (PIX_VALID && pix_ready_q) begin
          wdata_d   = {24'h0, PIX_DATA};
          awaddr_d  = ADDR_BASE + (32'(idx_q) * ADDR_STRIDE);
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        // Each channel completes independently; the response phase starts
        // only once both the address and the data have been taken.
        aw_done_d = aw_done_q | (awvalid_q & AWREADY);
        w_done_d  = w_done_q  | (wvalid_q & WREADY);
        if (aw_done_d && w_done_d) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (BVALID && bready_q) begin
          if (resp_err) begin
            error_d = 1'b1;
          end
          if (frame_end) begin
            state_d = S_FIN;
          end else begin
            idx_d   = idx_q + CNT_W'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    pix_ready_d = (state_d == S_FETCH);
    awvalid_d   = (state_d == S_WRITE) && !aw_done_d;
    wvalid_d    = (state_d == S_WRITE) && !w_done_d;
    bready_d    = (state_d == S_RESP);
    done_d      = (state_d == S_FIN);
    busy_d      = (state_d != S_IDLE);
  end

  // State register and registered outputs; reset abandons any transfer.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      pix_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      awaddr_q    <= 32'h0;
      wdata_q     <= 32'h0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      pix_ready_q <= pix_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ERROR     = error_q;
  assign PIX_READY = pix_ready_q;
  assign AWADDR    = awaddr_q;
  assign AWPROT    = 3'b000;
  assign AWVALID   = awvalid_q;
  assign WDATA     = wdata_q;
  assign WSTRB     = 4'b0001;
  assign WVALID    = wvalid_q;
  assign BREADY    = bready_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_img_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_axi_img_master
// Brief   : Scoreboard bench for axi_img_master. Pixel stimulus pushes the
//           expected write; a negedge monitor pops on AW/W handshakes and
//           checks frame completion. Honours AXI_IMG_MASTER_ABORT_EN.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_axi_img_master;

  localparam int          N         = 256;
  localparam logic [31:0] BASE      = 32'h0000_0000;
  localparam int          GUARD     = 4000;

  logic        ACLK;
  logic        ARESET;
  logic        START;
  logic        BUSY;
  logic        DONE;
  logic        ERROR;
  logic [7:0]  PIX_DATA;
  logic        PIX_VALID;
  logic        PIX_READY;
  logic [31:0] AWADDR;
  logic [2:0]  AWPROT;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;

  axi_img_master #(
    .N_PIXELS    (N),
    .ADDR_BASE   (BASE),
    .ADDR_STRIDE (32'd1)
  ) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .START     (START),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ERROR     (ERROR),
    .PIX_DATA  (PIX_DATA),
    .PIX_VALID (PIX_VALID),
    .PIX_READY (PIX_READY),
    .AWADDR    (AWADDR),
    .AWPROT    (AWPROT),
    .AWVALID   (AWVALID),
    .AWREADY   (AWREADY),
    .WDATA     (WDATA),
    .WSTRB     (WSTRB),
    .WVALID    (WVALID),
    .WREADY    (WREADY),
    .BRESP     (BRESP),
    .BVALID    (BVALID),
    .BREADY    (BREADY)
  );

  typedef struct {
    int   writes;
    int   offset;
    logic err;
  } done_t;

  int          checks = 0;
  int          errors = 0;
  int          edge_cnt = 0;
  int          start_edge = 0;
  int          wr_total = 0;
  int          b_total = 0;
  int          done_cnt = 0;
  int          wr_base = 0;
  int          b_base = 0;
  int          exp_aw_len = 1;

  logic [63:0] exp_wr_q[$];
  done_t       exp_done_q[$];

  // slave configuration
  int          aw_delay = 0;
  int          w_delay = 0;
  int          b_delay = 0;
  int          err_addr = -1;

  // handshake samples taken at negedge, consumed by the slave after the edge
  logic        aw_hs_n = 1'b0;
  logic        w_hs_n = 1'b0;
  logic        b_hs_n = 1'b0;
  logic [31:0] aw_addr_n = 32'h0;

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  always @(posedge ACLK) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs_zero();
    chk("rst_busy",      32'(BUSY),      32'h0);
    chk("rst_done",      32'(DONE),      32'h0);
    chk("rst_error",     32'(ERROR),     32'h0);
    chk("rst_pix_ready", 32'(PIX_READY), 32'h0);
    chk("rst_awvalid",   32'(AWVALID),   32'h0);
    chk("rst_wvalid",    32'(WVALID),    32'h0);
    chk("rst_bready",    32'(BREADY),    32'h0);
    chk("rst_awaddr",    AWADDR,         32'h0);
    chk("rst_wdata",     WDATA,          32'h0);
  endtask

  // Handshake sampler for the slave model
  always @(negedge ACLK) begin
    aw_hs_n = AWVALID && AWREADY && !ARESET;
    w_hs_n  = WVALID && WREADY && !ARESET;
    b_hs_n  = BVALID && BREADY && !ARESET;
    if (aw_hs_n) aw_addr_n = AWADDR;
  end

  // Slave model: programmable ready / response delays, error on one address
  initial begin : slave
    int          aw_cnt;
    int          w_cnt;
    int          b_cnt;
    logic        aw_got;
    logic        w_got;
    logic [31:0] cur_addr;
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; aw_got = 1'b0; w_got = 1'b0; cur_addr = 32'h0;
    forever begin
      @(posedge ACLK);
      #2;
      if (ARESET) begin
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; aw_got = 1'b0; w_got = 1'b0;
      end else begin
        if (b_hs_n) begin
          BVALID = 1'b0;
          BRESP  = 2'b00;
        end
        if (aw_hs_n) begin
          aw_got   = 1'b1;
          cur_addr = aw_addr_n;
        end
        if (w_hs_n) w_got = 1'b1;
        if (aw_got && w_got && !BVALID) begin
          if (b_cnt >= b_delay) begin
            BVALID = 1'b1;
            BRESP  = (int'(cur_addr) == err_addr) ? 2'b10 : 2'b00;
            aw_got = 1'b0;
            w_got  = 1'b0;
            b_cnt  = 0;
          end else begin
            b_cnt++;
          end
        end
        if (AWVALID && !aw_hs_n) begin
          if (aw_cnt >= aw_delay) AWREADY = 1'b1;
          else begin AWREADY = 1'b0; aw_cnt++; end
        end else begin
          AWREADY = 1'b0; aw_cnt = 0;
        end
        if (WVALID && !w_hs_n) begin
          if (w_cnt >= w_delay) WREADY = 1'b1;
          else begin WREADY = 1'b0; w_cnt++; end
        end else begin
          WREADY = 1'b0; w_cnt = 0;
        end
      end
    end
  end

  // Monitor / scoreboard
  logic [31:0] aw_cap[$];
  logic [31:0] w_cap[$];
  int          aw_len = 0;
  int          w_len = 0;
  logic [31:0] awaddr_prev = 32'h0;
  logic [31:0] wdata_prev = 32'h0;
  logic [31:0] cap_a;
  logic [31:0] cap_w;
  logic [63:0] exp_e;
  done_t       exp_d;

  always @(negedge ACLK) begin
    if (ARESET) begin
      aw_cap.delete();
      w_cap.delete();
      aw_len = 0;
      w_len  = 0;
    end else begin
      if (AWVALID) begin
        aw_len++;
        if (aw_len > 1) chk("awaddr_stable", AWADDR, awaddr_prev);
        awaddr_prev = AWADDR;
        if (AWREADY) begin
          aw_cap.push_back(AWADDR);
          chk("awprot", 32'(AWPROT), 32'h0);
          chk("aw_valid_cycles", 32'(aw_len), 32'(exp_aw_len));
          aw_len = 0;
        end
      end
      if (WVALID) begin
        w_len++;
        if (w_len > 1) chk("wdata_stable", WDATA, wdata_prev);
        wdata_prev = WDATA;
        if (WREADY) begin
          w_cap.push_back(WDATA);
          chk("wstrb", 32'(WSTRB), 32'h1);
          chk("w_valid_cycles", 32'(w_len), 32'h1);
          w_len = 0;
        end
      end
      while (aw_cap.size() > 0 && w_cap.size() > 0) begin
        cap_a = aw_cap.pop_front();
        cap_w = w_cap.pop_front();
        if (exp_wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=%0h required=none", cap_a);
        end else begin
          exp_e = exp_wr_q.pop_front();
          chk("awaddr", cap_a, exp_e[63:32]);
          chk("wdata",  cap_w, exp_e[31:0]);
        end
        wr_total++;
      end
      if (BVALID && BREADY) b_total++;
      if (DONE) begin
        done_cnt++;
        if (exp_done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          exp_d = exp_done_q.pop_front();
          chk("done_writes", 32'(wr_total - wr_base), 32'(exp_d.writes));
          chk("done_bresps", 32'(b_total - b_base),   32'(exp_d.writes));
          chk("done_cycle",  32'(edge_cnt - start_edge), 32'(exp_d.offset));
          chk("done_error",  32'(ERROR), 32'(exp_d.err));
          chk("done_busy",   32'(BUSY),  32'h1);
        end
      end
    end
  end

  // One frame: pixel k carries pat^k; optional 10-cycle stall before pixel stall_at
  task automatic run_frame(input logic [7:0] pat, input int stall_at, input int exp_writes,
                           input int exp_off, input logic exp_err, input bit hold_start);
    int k;
    int guard;
    int stall_left;
    int done_base;
    bit acc;
    k = 0; guard = 0; stall_left = 0;
    done_base = done_cnt;
    wr_base   = wr_total;
    b_base    = b_total;
    exp_done_q.push_back('{writes: exp_writes, offset: exp_off, err: exp_err});
    START     = 1'b1;
    PIX_VALID = 1'b1;
    PIX_DATA  = pat;
    @(posedge ACLK); #1;
    start_edge = edge_cnt;
    if (!hold_start) START = 1'b0;
    chk("busy_after_start", 32'(BUSY),  32'h1);
    chk("error_cleared",    32'(ERROR), 32'h0);
    while (done_cnt == done_base && guard < GUARD) begin
      @(negedge ACLK);
      acc = PIX_VALID && PIX_READY;
      @(posedge ACLK); #1;
      guard++;
      if (acc) begin
        exp_wr_q.push_back({BASE + 32'(k), 24'h0, PIX_DATA});
        k++;
        PIX_DATA = pat ^ 8'(k);
        if (k == stall_at) begin
          PIX_VALID  = 1'b0;
          stall_left = 10;
        end
      end else if (stall_left > 0) begin
        if (stall_left <= 8) begin
          chk("stall_no_awvalid", 32'(AWVALID),   32'h0);
          chk("stall_in_fetch",   32'(PIX_READY), 32'h1);
        end
        if (!hold_start) START = (stall_left == 5);
        stall_left--;
        if (stall_left == 0) PIX_VALID = 1'b1;
      end
    end
    if (done_cnt == done_base) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout actual=no_done required=done_within_%0d", GUARD);
    end
    PIX_VALID = 1'b0;
    START     = 1'b0;
    chk("done_one_cycle", 32'(DONE), 32'h0);
    chk("idle_not_busy",  32'(BUSY), 32'h0);
    repeat (3) begin
      @(posedge ACLK); #1;
    end
    chk("no_restart",      32'(BUSY), 32'h0);
    chk("scoreboard_empty", 32'(exp_wr_q.size()), 32'h0);
  endtask

  initial begin : main
    int guard;
    ARESET = 1'b1; START = 1'b0; PIX_VALID = 1'b0; PIX_DATA = 8'h00;
    repeat (3) @(posedge ACLK);
    #1;
    check_outputs_zero();
    ARESET = 1'b0;
    @(posedge ACLK); #1;

    // always-ready slave, pixel value equals index
    run_frame(8'h00, -1, N, 3 * N, 1'b0, 1'b0);

    // AWREADY 3 cycles late, BVALID one extra cycle late: 7 cycles per pixel
    aw_delay = 3; b_delay = 1; exp_aw_len = 4;
    run_frame(8'h5A, -1, N, 7 * N, 1'b0, 1'b0);
    aw_delay = 0; b_delay = 0; exp_aw_len = 1;

    // source stall before pixel 5 delays acceptance by 8 cycles; START pulse ignored
    run_frame(8'hA5, 5, N, 3 * N + 8, 1'b0, 1'b0);

    // SLVERR on pixel 7
    err_addr = 7;
`ifdef AXI_IMG_MASTER_ABORT_EN
    run_frame(8'h3C, -1, 8, 24, 1'b1, 1'b0);
`else
    run_frame(8'h3C, -1, N, 3 * N, 1'b1, 1'b0);
`endif
    err_addr = -1;
    chk("error_sticky", 32'(ERROR), 32'h1);

    // reset while AWVALID is waiting for AWREADY
    aw_delay = 3;
    START = 1'b1;
    @(posedge ACLK); #1;
    START = 1'b0;
    chk("start_clears_error", 32'(ERROR), 32'h0);
    PIX_VALID = 1'b1;
    PIX_DATA  = 8'h77;
    guard = 0;
    while (!AWVALID && guard < 20) begin
      @(posedge ACLK); #1;
      guard++;
    end
    chk("pre_reset_awvalid", 32'(AWVALID), 32'h1);
    chk("pre_reset_wdata",   WDATA,        32'h77);
    ARESET    = 1'b1;
    PIX_VALID = 1'b0;
    @(posedge ACLK); #1;
    check_outputs_zero();
    ARESET   = 1'b0;
    aw_delay = 0;

    // restart from pixel 0 with START held high for the whole frame
    run_frame(8'hC3, -1, N, 3 * N, 1'b0, 1'b1);

    chk("done_queue_empty", 32'(exp_done_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
